// File: rtl/dotacc_pkg.sv
// Shared types and width helpers for the dot-product accumulator.
package dotacc_pkg;

  localparam int unsigned BEATS_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Accumulator width: product width plus per-beat reduction growth plus guard bits.
  function automatic int unsigned acc_width(input int unsigned w, input int unsigned n,
                                            input int unsigned guard);
    return 2 * w + clog2(n) + guard;
  endfunction

endpackage

// File: rtl/dot_product_accumulator_if.sv
// Beat input and result output handshakes of the dot-product accumulator.
interface dot_product_accumulator_if #(
  parameter int unsigned W     = 8,
  parameter int unsigned N     = 8,
  parameter int unsigned M     = 2,
  parameter int unsigned ACC_W = 27
);
  logic                          in_valid;
  logic                          in_ready;
  logic                          in_last;
  logic [M*N*2*W-1:0]            in_products;
  logic                          out_valid;
  logic                          out_ready;
  logic [M*ACC_W-1:0]            out_sums;
  logic [M-1:0]                  out_overflow;
  logic [dotacc_pkg::BEATS_W-1:0] out_beats;

  modport master (
    output in_valid, in_last, in_products, out_ready,
    input  in_ready, out_valid, out_sums, out_overflow, out_beats
  );

  modport slave (
    input  in_valid, in_last, in_products, out_ready,
    output in_ready, out_valid, out_sums, out_overflow, out_beats
  );
endinterface

// File: rtl/dotacc_lane.sv
// One lane's running sum; clamps and flags on carry-out when DOTACC_SATURATE_EN is defined,
// otherwise wraps modulo 2^ACC_W with the overflow flag tied low.
module dotacc_lane #(
  parameter int unsigned P_W   = 16,
  parameter int unsigned ACC_W = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             add_en,
  input  logic             clr,
  input  logic [P_W-1:0]   product,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  logic [ACC_W-1:0] acc_q, acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

`ifdef DOTACC_SATURATE_EN
  localparam int unsigned SUM_W = ACC_W + 1;

  logic [SUM_W-1:0] sum_c;
  logic             ovf_q, ovf_d;

  // Extra top bit captures the carry that triggers the clamp.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    sum_c = SUM_W'(acc_q) + SUM_W'(product);
    if (clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (add_en) begin
      if (sum_c[ACC_W]) begin
        acc_d = '1;
        ovf_d = 1'b1;
      end else begin
        acc_d = sum_c[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  always_comb begin
    acc_d = acc_q;
    if (clr)         acc_d = '0;
    else if (add_en) acc_d = acc_q + ACC_W'(product);
  end

  assign ovf = 1'b0;
`endif

  assign acc = acc_q;

endmodule

// File: rtl/dot_product_accumulator.sv
// Reduces M lanes of N products per beat into per-lane sums across beats until a last beat.
// Optional saturation on lane overflow: define DOTACC_SATURATE_EN.
module dot_product_accumulator
  import dotacc_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned N     = 8,
  parameter int unsigned M     = 2,
  parameter int unsigned GUARD = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  dot_product_accumulator_if.slave bus
);

  localparam int unsigned P_W   = 2 * W;
  localparam int unsigned ACC_W = acc_width(W, N, GUARD);
  localparam int unsigned IDX_W = (N > 1) ? clog2(N) : 1;
  localparam int unsigned BUF_W = M * N * P_W;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               last_q, last_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [BEATS_W-1:0] beats_q, beats_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               add_en_c, clr_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      last_q      <= 1'b0;
      buf_q       <= '0;
      beats_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      buf_q       <= buf_d;
      beats_q     <= beats_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Handshake flags are registered from the next state so they line up with state_q.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    buf_d    = buf_q;
    beats_d  = beats_q;
    add_en_c = 1'b0;
    clr_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          buf_d   = bus.in_products;
          last_d  = bus.in_last;
          idx_d   = '0;
          if (beats_q != '1) beats_d = beats_q + BEATS_W'(1);
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        add_en_c = 1'b1;
        idx_d    = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N - 1)) begin
          idx_d   = '0;
          state_d = last_q ? OUTPUT : IDLE;
        end
      end
      OUTPUT: begin
        if (bus.out_ready) begin
          clr_c   = 1'b1;
          beats_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == OUTPUT);
  end

  for (genvar i = 0; i < M; i++) begin : g_lane
    logic [P_W-1:0]   prod_c;
    logic [ACC_W-1:0] acc;
    logic             ovf;

    assign prod_c = buf_q[P_W * (i * N + int'(idx_q)) +: P_W];

    dotacc_lane #(
      .P_W   (P_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .add_en  (add_en_c),
      .clr     (clr_c),
      .product (prod_c),
      .acc     (acc),
      .ovf     (ovf)
    );

    assign bus.out_sums[i*ACC_W +: ACC_W] = acc;
    assign bus.out_overflow[i]            = ovf;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_beats = beats_q;

endmodule
